// File: rtl/dsp_handshake_sequencer.sv
// rtl/dsp_handshake_sequencer.sv - valid/ready flow control for a fixed-latency DSP48A1 pipeline
//
// Purpose: tracks which samples are in flight through the configured DSP48A1
// register stages. It drives one common clock enable to all of them and flags
// out_valid/out_last in the same cycle the matching result is on P.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   flush           discard every in-flight sample on the next edge
//   in_valid/in_last/in_ready    upstream handshake
//   dsp_ce          common CE for every DSP48A1 register stage
//   out_valid/out_last/out_ready downstream handshake on P
//   inflight        count of valid samples held in the stages (0..L)
//   burst_count     completed output bursts, wraps at 16'hFFFF
module dsp_handshake_sequencer #(
  parameter int A0REG = 0,
  parameter int A1REG = 1,
  parameter int B0REG = 0,
  parameter int B1REG = 1,
  parameter int DREG  = 1,
  parameter int MREG  = 1,
  parameter int PREG  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        dsp_ce,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [2:0]  inflight,
  output logic [15:0] burst_count
);

  localparam int A_LAT  = A0REG + A1REG;
  localparam int B_LAT  = B0REG + B1REG;
  // D joins the B path through the pre-adder, so it also goes through B1REG.
  localparam int D_LAT  = DREG + B1REG;
  localparam int AB_LAT = (A_LAT > B_LAT) ? A_LAT : B_LAT;
  localparam int IN_LAT = (AB_LAT > D_LAT) ? AB_LAT : D_LAT;
  localparam int L      = IN_LAT + MREG + PREG;

  logic [15:0] burst_count_q, burst_count_d;

  generate
    if (L == 0) begin : g_bypass
      // No stages: the handshake passes straight through.
      assign dsp_ce    = 1'b1;
      assign in_ready  = out_ready & ~flush & ~rst;
      assign out_valid = in_valid;
      assign out_last  = in_last & in_valid;
      assign inflight  = 3'd0;
    end else begin : g_pipe
      logic [L-1:0] vld_q, vld_d;
      logic [L-1:0] lst_q, lst_d;
      logic [2:0]   inflight_q, inflight_d;
      logic         accept;

      // Stall only when P holds a result nobody takes. Bubbles still move.
      assign dsp_ce    = ~vld_q[L-1] | out_ready;
      assign in_ready  = dsp_ce & ~flush & ~rst;
      assign accept    = in_valid & in_ready;
      assign out_valid = vld_q[L-1];
      assign out_last  = lst_q[L-1] & vld_q[L-1];
      assign inflight  = inflight_q;

      always_comb begin
        vld_d      = vld_q;
        lst_d      = lst_q;
        inflight_d = 3'd0;
        if (flush) begin
          vld_d = '0;
          lst_d = '0;
        end else if (dsp_ce) begin
          vld_d[0] = accept;
          lst_d[0] = accept & in_last;
          for (int i = 1; i < L; i++) begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
          end
        end
        // Count from the next state so inflight agrees with vld_q in every cycle.
        for (int i = 0; i < L; i++) begin
          inflight_d = inflight_d + {2'b00, vld_d[i]};
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q      <= '0;
          lst_q      <= '0;
          inflight_q <= 3'd0;
        end else begin
          vld_q      <= vld_d;
          lst_q      <= lst_d;
          inflight_q <= inflight_d;
        end
      end
    end
  endgenerate

  // An output handshake during a flush cycle still completes its burst.
  always_comb begin
    burst_count_d = burst_count_q;
    if (out_valid && out_ready && out_last) begin
      burst_count_d = burst_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_count_q <= 16'd0;
    end else begin
      burst_count_q <= burst_count_d;
    end
  end

  assign burst_count = burst_count_q;

endmodule

// File: tb/tb_dsp_handshake_sequencer.sv
// tb/tb_dsp_handshake_sequencer.sv - directed bench for dsp_handshake_sequencer
module tb_dsp_handshake_sequencer;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_last, out_ready;

  logic        in_ready_4, dsp_ce_4, out_valid_4, out_last_4;
  logic [2:0]  inflight_4;
  logic [15:0] burst_4;
  logic        in_ready_0, dsp_ce_0, out_valid_0, out_last_0;
  logic [2:0]  inflight_0;
  logic [15:0] burst_0;
  logic        in_ready_1, dsp_ce_1, out_valid_1, out_last_1;
  logic [2:0]  inflight_1;
  logic [15:0] burst_1;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  // Default configuration, L = 4.
  dsp_handshake_sequencer u_l4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_4), .dsp_ce(dsp_ce_4), .out_valid(out_valid_4),
    .out_last(out_last_4), .out_ready(out_ready), .inflight(inflight_4),
    .burst_count(burst_4)
  );

  // Bypass, L = 0.
  dsp_handshake_sequencer #(
    .A0REG(0), .A1REG(0), .B0REG(0), .B1REG(0), .DREG(0), .MREG(0), .PREG(0)
  ) u_l0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_0), .dsp_ce(dsp_ce_0), .out_valid(out_valid_0),
    .out_last(out_last_0), .out_ready(out_ready), .inflight(inflight_0),
    .burst_count(burst_0)
  );

  // P register only, L = 1.
  dsp_handshake_sequencer #(
    .A0REG(0), .A1REG(0), .B0REG(0), .B1REG(0), .DREG(0), .MREG(0), .PREG(1)
  ) u_l1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_1), .dsp_ce(dsp_ce_1), .out_valid(out_valid_1),
    .out_last(out_last_1), .out_ready(out_ready), .inflight(inflight_1),
    .burst_count(burst_1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Apply one cycle of inputs just after the falling edge, then settle.
  task automatic drive(input logic v, input logic l, input logic r, input logic f, input logic rs);
    @(negedge clk);
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    flush     = f;
    rst       = rs;
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 1, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, hs, ov;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;

    // Reset state, checked while rst is still high.
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 1, 0, 1);
    chk("rst_out_valid", out_valid_4, 0);
    chk("rst_out_last", out_last_4, 0);
    chk("rst_inflight", inflight_4, 0);
    chk("rst_burst", burst_4, 0);
    chk("rst_dsp_ce", dsp_ce_4, 1);
    chk("rst_in_ready", in_ready_4, 0);

    // 8 back-to-back samples, last on the 8th. Cycle c is the edge index.
    // Sample j is accepted at edge j and reaches P after edge j+3.
    hs = 0;
    for (int c = 0; c < 14; c++) begin
      drive(c < 8, c == 7, 1, 0, 0);
      cnt = 0;
      for (int j = 0; j < 8; j++) if (j >= c - 4 && j <= c - 1) cnt++;
      if (cnt > hs) hs = cnt;
      chk($sformatf("b2b_valid_c%0d", c), out_valid_4, (c >= 4 && c <= 11));
      chk($sformatf("b2b_last_c%0d", c), out_last_4, (c == 11));
      chk($sformatf("b2b_inflight_c%0d", c), inflight_4, cnt);
      if (c < 8) chk($sformatf("b2b_in_ready_c%0d", c), in_ready_4, 1);
    end
    chk("b2b_peak_inflight", hs, 4);
    chk("b2b_burst", burst_4, 1);

    // Backpressure: 4 samples, out_ready drops when the first result arrives.
    do_reset();
    for (int c = 0; c < 4; c++) drive(1, 0, 1, 0, 0);
    for (int c = 4; c < 7; c++) begin
      drive(1, 0, 0, 0, 0);
      chk($sformatf("bp_dsp_ce_c%0d", c), dsp_ce_4, 0);
      chk($sformatf("bp_in_ready_c%0d", c), in_ready_4, 0);
      chk($sformatf("bp_inflight_c%0d", c), inflight_4, 4);
      chk($sformatf("bp_valid_c%0d", c), out_valid_4, 1);
    end
    hs = 0;
    for (int c = 7; c < 13; c++) begin
      drive(0, 0, 1, 0, 0);
      chk($sformatf("bp_drain_valid_c%0d", c), out_valid_4, (c <= 10));
      if (out_valid_4) hs++;
    end
    chk("bp_outputs", hs, 4);
    chk("bp_burst", burst_4, 0);

    // Flush with 3 samples in flight.
    do_reset();
    for (int c = 0; c < 3; c++) drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 1, 0);
    chk("fl_in_ready", in_ready_4, 0);
    chk("fl_inflight_before", inflight_4, 3);
    ov = out_valid_4;
    drive(0, 0, 1, 0, 0);
    chk("fl_inflight_after", inflight_4, 0);
    for (int c = 0; c < 6; c++) begin
      ov += out_valid_4;
      drive(0, 0, 1, 0, 0);
    end
    chk("fl_no_output", ov, 0);
    chk("fl_burst", burst_4, 0);

    // Reset in the middle of a burst.
    do_reset();
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 1);
    chk("rm_in_ready", in_ready_4, 0);
    drive(1, 1, 1, 0, 0);
    chk("rm_out_valid", out_valid_4, 0);
    chk("rm_out_last", out_last_4, 0);
    chk("rm_inflight", inflight_4, 0);
    chk("rm_burst", burst_4, 0);
    chk("rm_dsp_ce", dsp_ce_4, 1);
    ov = 0;
    for (int c = 4; c < 9; c++) begin
      drive(0, 0, 1, 0, 0);
      ov += out_valid_4;
      if (c == 7) chk("rm_out_last_late", out_last_4, 1);
    end
    chk("rm_single_output", ov, 1);
    chk("rm_burst_after", burst_4, 1);

    // Bypass configuration.
    do_reset();
    drive(1, 0, 1, 0, 0);
    chk("l0_valid_r1", out_valid_0, 1);
    chk("l0_ready_r1", in_ready_0, 1);
    chk("l0_ce_r1", dsp_ce_0, 1);
    drive(1, 1, 0, 0, 0);
    chk("l0_valid_r0", out_valid_0, 1);
    chk("l0_last_r0", out_last_0, 1);
    chk("l0_ready_r0", in_ready_0, 0);
    chk("l0_ce_r0", dsp_ce_0, 1);
    drive(1, 0, 1, 0, 0);
    chk("l0_ready_r1b", in_ready_0, 1);
    chk("l0_ce_r1b", dsp_ce_0, 1);
    chk("l0_inflight", inflight_0, 0);
    drive(0, 1, 1, 0, 0);
    chk("l0_valid_off", out_valid_0, 0);
    chk("l0_last_off", out_last_0, 0);

    // Wrap at L = 1: 65535 single-sample last bursts, then one more.
    do_reset();
    for (int k = 0; k < 65535; k++) drive(1, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    chk("wrap_ffff", burst_1, 16'hFFFF);
    drive(1, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    chk("wrap_zero", burst_1, 0);

    // An output handshake during a flush still counts.
    drive(1, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 0);
    chk("flhs_valid", out_valid_1, 1);
    drive(0, 0, 1, 0, 0);
    chk("flhs_burst", burst_1, 1);
    chk("flhs_valid_after", out_valid_1, 0);

    // Reset wins over flush and clears the counter.
    drive(0, 0, 1, 1, 1);
    drive(0, 0, 1, 0, 0);
    chk("rstfl_burst", burst_1, 0);
    chk("rstfl_inflight", inflight_1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dsp_handshake_sequencer.md
# dsp_handshake_sequencer

Flow-control sequencer on the output side of the DSP48A1 datapath. It gives a valid/ready handshake to a pipeline built from fixed, parameter-selected register stages. It tracks which samples are in flight through the configured stages, drives a single clock enable to every stage, and asserts `out_valid`/`out_last` in the same cycle the matching result appears on P. It sits between the upstream producer, the DSP48A1 top-level CE inputs, and the downstream consumer of P.

## Interface
- `A0REG`, default 0, A first-stage register present (0/1)
- `A1REG`, default 1, A second-stage register present (0/1)
- `B0REG`, default 0, B first-stage register present (0/1)
- `B1REG`, default 1, B second-stage register present (0/1)
- `DREG`, default 1, D register present (0/1)
- `MREG`, default 1, multiplier output register present (0/1)
- `PREG`, default 1, P output register present (0/1)
- `clk`  input  1  single clock, all logic on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `flush`  input  1  synchronous discard of all in-flight samples
- `in_valid`  input  1  upstream sample (A/B/D/C/OPMODE) present this cycle
- `in_last`  input  1  sample is last of a burst, qualified by `in_valid`
- `in_ready`  output  1  sample accepted when `in_valid & in_ready`
- `dsp_ce`  output  1  common clock enable to every DSP48A1 CE input
- `out_valid`  output  1  P holds a valid result
- `out_last`  output  1  result is last of a burst, qualified by `out_valid`
- `out_ready`  input  1  downstream accepts P when `out_valid & out_ready`
- `inflight`  output  3  number of valid samples currently held in pipeline stages (0..L)
- `burst_count`  output  16  completed output bursts, wraps at 16'hFFFF -> 0

## Operation
- Latency `L = max(A0REG+A1REG, B0REG+B1REG, DREG+B1REG) + MREG + PREG`, range 0..4, fixed at elaboration.
- The C and OPMODE alignment is the producer's responsibility; this block only tracks the A/B/D path.
- State: `L`-bit valid shift register `vld[0..L-1]` and `L`-bit last shift register `lst[0..L-1]`. Bit `L-1` is the P stage.
- `dsp_ce = ~out_valid | out_ready`. The pipeline advances exactly when `dsp_ce` is 1.
- `in_ready = dsp_ce & ~flush & ~rst`.
- On an advance: `vld[0] <= in_valid & in_ready`, `lst[0] <= in_last & in_valid & in_ready`, and `vld[i] <= vld[i-1]` for the other stages (same for `lst`).
- Without an advance, all shift-register bits hold.
- `out_valid = vld[L-1]` and `out_last = lst[L-1] & vld[L-1]`.
- `inflight` is the popcount of `vld`, registered from next-state so it matches the shift register in the same cycle.
- `burst_count` increments on every cycle where `out_valid & out_ready & out_last`.
- `flush`:
  - next cycle all `vld`/`lst` are 0 and `inflight` is 0.
  - `in_ready` is 0 during the flush cycle, so no sample is accepted.
  - `burst_count` is unaffected.
  - A handshake on the output during the flush cycle still counts.
- `L = 0`:
  - No shift registers.
  - `out_valid = in_valid`, `out_last = in_last & in_valid`, `in_ready = out_ready & ~flush & ~rst`.
  - `dsp_ce = 1` and `inflight = 0`.
- Data on A/B/D/P is not routed through this block.

## Timing
- Reset (`rst` high at a rising edge) gives:
  - `vld` = 0, `lst` = 0
  - `out_valid` = 0, `out_last` = 0
  - `inflight` = 0, `burst_count` = 0
  - which makes `dsp_ce` = 1
  - `in_ready` is 0 while `rst` is high.
- Reset mid-burst drops all in-flight samples; the partial burst is not counted.
- With no stalls, a sample accepted at edge n has `out_valid` high after edge n+L-1. This matches P being updated after L enabled edges.
- A stall (`out_valid & ~out_ready`) freezes every stage, including P, for exactly that cycle.
- Full throughput: one sample per cycle is accepted while `out_ready` stays high.
- Bubbles propagate; `dsp_ce` does not compress bubbles.
- `flush` and `rst` in the same cycle: reset wins, and `burst_count` clears.

## Test plan
- Defaults (L=4): reset, then 8 back-to-back samples with `out_ready=1` and `in_last` on the 8th. Required: `out_valid` high for 8 consecutive cycles starting 3 cycles after the first accept, `out_last` on the 8th, `burst_count`=1, `inflight` peaks at 4.
- Backpressure: 4 samples with `out_ready=0` from the first `out_valid`. Required: `dsp_ce`=0 and `in_ready`=0 while stalled, `inflight`=4 held. After `out_ready` rises, the remaining results drain one per cycle, 4 outputs in total.
- Flush mid-pipeline: accept 3 samples, assert `flush` for 1 cycle. Required: next cycle `inflight`=0, no `out_valid` ever appears, and `in_ready`=0 during the flush cycle.
- Reset mid-burst: accept 2 samples (no last), assert `rst`. Required: all outputs return to reset values, `burst_count`=0, and a following 1-sample last burst gives `burst_count`=1.
- Bypass configuration (all *REG=0, L=0): `in_valid=1`, `out_ready` toggling 1,0,1. Required: `out_valid` follows `in_valid` combinationally, `in_ready` follows `out_ready`, `dsp_ce`=1 constantly.
- Wrap: preload via 65535 single-sample last bursts at L=1. Required: `burst_count`=16'hFFFF, and one more gives 0.
